sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares one single-port synchronous SRAM between the instruction-fetch requester (IF stage) and the data requester (EXE/MEM stages).
- Sits between the pipeline stages and memory, and replaces the separate inst/data SRAM ports with a single physical port.
- Provides a req/addr_ok/data_ok handshake per requester, fixed-priority arbitration with an anti-starvation counter, a tagged response pipeline, and cancellation of in-flight fetches on redirect.

Parameters:
LAT, 1, SRAM read latency in cycles from the en cycle to rdata valid (legal values 1..4)
MAX_WAIT, 3, number of consecutive lost arbitration cycles after which inst overrides data priority (1..15)

Ports:
clk  in  1  clock, all state updates on the rising edge
reset  in  1  synchronous, active-high reset
inst_req  in  1  IF requests an access this cycle
inst_we  in  4  IF byte write enables (0 = read)
inst_addr  in  32  IF byte address
inst_wdata  in  32  IF write data
inst_addr_ok  out  1  IF request accepted this cycle
inst_data_ok  out  1  IF response valid this cycle (1-cycle pulse)
inst_rdata  out  32  IF read data, qualified by inst_data_ok
inst_cancel  in  1  IF redirect: drop all in-flight inst responses
data_req  in  1  data requester access request
data_we  in  4  data byte write enables
data_addr  in  32  data byte address
data_wdata  in  32  data write data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  data response valid (1-cycle pulse, reads and writes)
data_rdata  out  32  data read data, qualified by data_data_ok
sram_en  out  1  SRAM enable
sram_we  out  4  SRAM byte write enables
sram_addr  out  32  SRAM address
sram_wdata  out  32  SRAM write data
sram_rdata  in  32  SRAM read data, valid LAT cycles after the en cycle

Behaviour:
- Reset: starve_cnt=0 and all tag-pipeline entries invalid. While reset is high, every output is 0 (addr_ok, data_ok, sram_en, sram_we, and all data buses).
- Reset mid-operation: all in-flight responses are discarded; no data_ok is issued for them after reset.
- Arbitration (combinational, at most one grant per cycle):
  - grant_inst = inst_req & ~inst_cancel & (~data_req | starve_cnt==MAX_WAIT)
  - grant_data = data_req & ~grant_inst
  - addr_ok of the granted requester = 1 in the same cycle. A requester holds req and its payload until it sees addr_ok.
- SRAM drive:
  - sram_en = grant_inst | grant_data.
  - we, addr and wdata are muxed from the granted requester.
  - When there is no grant, sram_we, sram_addr and sram_wdata are 0.
- starve_cnt (4 bits):
  - cleared when inst is granted, or when inst_req is 0 (including during inst_cancel cycles).
  - +1 when inst_req=1 and not granted; saturates at MAX_WAIT.
- Tag pipeline:
  - LAT stages of {valid, owner (0=inst, 1=data), dead}. Stage 0 loads {sram_en, grant_data, 0} every cycle; each stage shifts one per cycle.
  - A response appears at the last stage exactly LAT cycles after its addr_ok cycle.
  - Back-to-back grants are fully pipelined; there is no bubble between requests.
- Response:
  - If the last stage is valid and not dead, the owner's data_ok = 1 for one cycle and its rdata = sram_rdata; the other requester's rdata = 0.
  - Writes also return data_ok, with rdata = sram_rdata (content don't-care).
- inst_cancel:
  - Sets dead on every valid inst-owned stage in the same edge. Dead entries produce no inst_data_ok.
  - Data-owned entries are unaffected.
  - Inst is not granted in the cancel cycle, so data may be granted freely that cycle.
  - Cancel with nothing in flight is a no-op.
- Simultaneous events:
  - Data may be granted in the same cycle a data response returns.
  - inst_data_ok and data_data_ok are never both 1 in the same cycle.
- Requesters must accept data_ok unconditionally; there is no response back-pressure.

Test Plan:
- Single inst read, LAT=1, SRAM word at 0x1c000000 = 0x02800c0c: inst_req at cycle 0 gives inst_addr_ok=1 at cycle 0, sram_en=1 with sram_addr=0x1c000000, then inst_data_ok=1 with inst_rdata=0x02800c0c at cycle 1.
- Contention, MAX_WAIT=3, both requesters held high: data is granted at cycles 0,1,2 and inst at cycle 3 (starve_cnt=3); starve_cnt is 0 at cycle 4 and data is granted again.
- Back-to-back data: store we=0xf to 0x100 with wdata 0xdeadbeef, then load 0x100 the next cycle. Both addr_ok=1 with consecutive grants, data_data_ok at cycles 1 and 2, and the load returns 0xdeadbeef.
- Cancel, LAT=3: inst granted at cycles 0 and 1, inst_cancel at cycle 2. No inst_data_ok at cycles 3 or 4. A data request at cycle 2 is granted and its data_data_ok arrives at cycle 5.
- Reset mid-flight, LAT=2: inst granted at cycle 0, reset at cycle 1. No data_ok at cycle 2; all outputs are 0 during reset and starve_cnt=0 after it.
- Idle with no requests for 10 cycles: sram_en=0 and both data_ok=0 throughout.

Source files
------------

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and data access.
// Data has fixed priority, but a fetch that keeps losing is eventually granted.
module sram_arbiter #(
  parameter int unsigned LAT      = 1,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [3:0]  inst_we,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_cancel,
  input  logic        data_req,
  input  logic [3:0]  data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic           grant_inst;
  logic           grant_data;
  logic           grant_any;
  logic [3:0]     starve_cnt_q, starve_cnt_d;
  logic [LAT-1:0] tag_vld_q, tag_vld_d;
  logic [LAT-1:0] tag_own_q, tag_own_d;
  logic [LAT-1:0] tag_dead_q, tag_dead_d;
  logic           resp_vld;

  // Grants are forced low during reset so that no access starts and no tag is loaded.
  always_comb begin
    grant_inst = ~reset & inst_req & ~inst_cancel & (~data_req | (starve_cnt_q == MaxWait));
    grant_data = ~reset & data_req & ~grant_inst;
    grant_any  = grant_inst | grant_data;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_inst || !inst_req) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != MaxWait) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // A redirect marks every in-flight fetch dead as it shifts, so it never reaches the IF stage.
  always_comb begin
    tag_vld_d     = '0;
    tag_own_d     = '0;
    tag_dead_d    = '0;
    tag_vld_d[0]  = grant_any;
    tag_own_d[0]  = grant_data;
    tag_dead_d[0] = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_own_d[i]  = tag_own_q[i-1];
      tag_dead_d[i] = tag_dead_q[i-1] | (inst_cancel & tag_vld_q[i-1] & ~tag_own_q[i-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      tag_vld_q    <= '0;
      tag_own_q    <= '0;
      tag_dead_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      tag_vld_q    <= tag_vld_d;
      tag_own_q    <= tag_own_d;
      tag_dead_q   <= tag_dead_d;
    end
  end

  always_comb begin
    resp_vld     = ~reset & tag_vld_q[LAT-1] & ~tag_dead_q[LAT-1];
    inst_data_ok = resp_vld & ~tag_own_q[LAT-1];
    data_data_ok = resp_vld & tag_own_q[LAT-1];
    inst_rdata   = inst_data_ok ? sram_rdata : '0;
    data_rdata   = data_data_ok ? sram_rdata : '0;
    inst_addr_ok = grant_inst;
    data_addr_ok = grant_data;
    sram_en      = grant_any;
    sram_we      = '0;
    sram_addr    = '0;
    sram_wdata   = '0;
    if (grant_inst) begin
      sram_we    = inst_we;
      sram_addr  = inst_addr;
      sram_wdata = inst_wdata;
    end else if (grant_data) begin
      sram_we    = data_we;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: three instances with LAT = 1, 2, 3 sharing one clock, each with an SRAM
// model and an in-order scoreboard; directed sequences run against one instance at a time.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       reset, inst_req, inst_cancel, data_req;
  logic [2:0][3:0]  inst_we, data_we;
  logic [2:0][31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  wire  [2:0]       inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, sram_en;
  wire  [2:0][31:0] inst_rdata, data_rdata, sram_addr, sram_wdata, sram_rdata;
  wire  [2:0][3:0]  sram_we;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int Lat = g + 1;
    typedef struct packed {
      logic        owner;
      logic        chk;
      logic [31:0] val;
      int          issue;
    } exp_t;

    logic [31:0] mem [256];
    logic [31:0] shadow [256];
    logic [31:0] rd_pipe [4];
    exp_t        sb [$];
    exp_t        kq [$];
    exp_t        e;
    logic        exp_i, exp_d;
    logic [3:0]  we;
    logic [31:0] a, wd;

    sram_arbiter #(.LAT(Lat), .MAX_WAIT(3)) u_dut (
      .clk          (clk),
      .reset        (reset[g]),
      .inst_req     (inst_req[g]),
      .inst_we      (inst_we[g]),
      .inst_addr    (inst_addr[g]),
      .inst_wdata   (inst_wdata[g]),
      .inst_addr_ok (inst_addr_ok[g]),
      .inst_data_ok (inst_data_ok[g]),
      .inst_rdata   (inst_rdata[g]),
      .inst_cancel  (inst_cancel[g]),
      .data_req     (data_req[g]),
      .data_we      (data_we[g]),
      .data_addr    (data_addr[g]),
      .data_wdata   (data_wdata[g]),
      .data_addr_ok (data_addr_ok[g]),
      .data_data_ok (data_data_ok[g]),
      .data_rdata   (data_rdata[g]),
      .sram_en      (sram_en[g]),
      .sram_we      (sram_we[g]),
      .sram_addr    (sram_addr[g]),
      .sram_wdata   (sram_wdata[g]),
      .sram_rdata   (sram_rdata[g])
    );

    assign sram_rdata[g] = rd_pipe[g];

    // Synchronous SRAM with Lat cycles of read latency, read-before-write.
    always @(posedge clk) begin
      if (reset[g]) begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = 32'h02800c0c;
      end
      if (sram_en[g]) begin
        rd_pipe[0] <= mem[sram_addr[g][9:2]];
        for (int b = 0; b < 4; b++)
          if (sram_we[g][b]) mem[sram_addr[g][9:2]][8*b +: 8] = sram_wdata[g][8*b +: 8];
      end
      for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Scoreboard: every accepted request is due exactly Lat cycles later unless cancelled.
    always @(negedge clk) begin
      if (reset[g]) begin
        sb.delete();
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        shadow[0] = 32'h02800c0c;
      end else begin
        exp_i = 1'b0;
        exp_d = 1'b0;
        e     = '0;
        if (sb.size() > 0 && sb[0].issue + Lat == cyc) begin
          e     = sb.pop_front();
          exp_i = ~e.owner;
          exp_d = e.owner;
        end
        check($sformatf("d%0d_c%0d_inst_data_ok", g, cyc), inst_data_ok[g], exp_i);
        check($sformatf("d%0d_c%0d_data_data_ok", g, cyc), data_data_ok[g], exp_d);
        if (!exp_i) check($sformatf("d%0d_c%0d_inst_rdata_idle", g, cyc), inst_rdata[g], 0);
        else if (e.chk) check($sformatf("d%0d_c%0d_inst_rdata", g, cyc), inst_rdata[g], e.val);
        if (!exp_d) check($sformatf("d%0d_c%0d_data_rdata_idle", g, cyc), data_rdata[g], 0);
        else if (e.chk) check($sformatf("d%0d_c%0d_data_rdata", g, cyc), data_rdata[g], e.val);
        check($sformatf("d%0d_c%0d_one_grant", g, cyc), inst_addr_ok[g] & data_addr_ok[g], 0);
        if (inst_cancel[g]) begin
          kq.delete();
          foreach (sb[i]) if (sb[i].owner) kq.push_back(sb[i]);
          sb = kq;
        end
        if (inst_addr_ok[g] || data_addr_ok[g]) begin
          e.owner = data_addr_ok[g];
          we      = e.owner ? data_we[g] : inst_we[g];
          a       = e.owner ? data_addr[g] : inst_addr[g];
          wd      = e.owner ? data_wdata[g] : inst_wdata[g];
          e.chk   = (we == 4'h0);
          e.val   = shadow[a[9:2]];
          e.issue = cyc;
          for (int b = 0; b < 4; b++) if (we[b]) shadow[a[9:2]][8*b +: 8] = wd[8*b +: 8];
          sb.push_back(e);
        end
      end
    end
  end

  initial begin
    reset       = '1;
    inst_req    = '0;
    inst_cancel = '0;
    data_req    = '0;
    inst_we     = '0;
    data_we     = '0;
    inst_addr   = '0;
    data_addr   = '0;
    inst_wdata  = '0;
    data_wdata  = '0;
    repeat (2) tick();
    reset = '0;
    tick();

    // Single fetch, LAT=1.
    inst_req[0]  = 1'b1;
    inst_addr[0] = 32'h1c000000;
    @(negedge clk);
    check("t1_inst_addr_ok", inst_addr_ok[0], 1);
    check("t1_sram_en", sram_en[0], 1);
    check("t1_sram_addr", sram_addr[0], 32'h1c000000);
    tick();
    inst_req[0] = 1'b0;
    @(negedge clk);
    check("t1_inst_data_ok", inst_data_ok[0], 1);
    check("t1_inst_rdata", inst_rdata[0], 32'h02800c0c);
    tick();

    // Contention: data wins three times, then the starved fetch gets through.
    inst_req[0]  = 1'b1;
    inst_addr[0] = 32'h4;
    data_req[0]  = 1'b1;
    data_addr[0] = 32'h1c000000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("t2_inst_grant_c%0d", c), inst_addr_ok[0], (c % 4 == 3));
      check($sformatf("t2_data_grant_c%0d", c), data_addr_ok[0], (c % 4 != 3));
      tick();
    end
    inst_req[0] = 1'b0;
    data_req[0] = 1'b0;
    repeat (3) tick();

    // Back-to-back store then load.
    data_req[0]   = 1'b1;
    data_we[0]    = 4'hf;
    data_addr[0]  = 32'h100;
    data_wdata[0] = 32'hdeadbeef;
    @(negedge clk);
    check("t3_st_addr_ok", data_addr_ok[0], 1);
    check("t3_st_sram_we", sram_we[0], 4'hf);
    check("t3_st_sram_wdata", sram_wdata[0], 32'hdeadbeef);
    tick();
    data_we[0]    = 4'h0;
    data_wdata[0] = '0;
    @(negedge clk);
    check("t3_ld_addr_ok", data_addr_ok[0], 1);
    check("t3_st_data_ok", data_data_ok[0], 1);
    tick();
    data_req[0] = 1'b0;
    @(negedge clk);
    check("t3_ld_data_ok", data_data_ok[0], 1);
    check("t3_ld_rdata", data_rdata[0], 32'hdeadbeef);
    repeat (3) tick();

    // Idle.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("t6_sram_en_c%0d", c), sram_en[0], 0);
      check($sformatf("t6_inst_data_ok_c%0d", c), inst_data_ok[0], 0);
      check($sformatf("t6_data_data_ok_c%0d", c), data_data_ok[0], 0);
      tick();
    end

    // Cancel, LAT=3.
    inst_req[2]  = 1'b1;
    inst_addr[2] = 32'h1c000000;
    @(negedge clk);
    check("t4_i0_addr_ok", inst_addr_ok[2], 1);
    tick();
    inst_addr[2] = 32'h4;
    @(negedge clk);
    check("t4_i1_addr_ok", inst_addr_ok[2], 1);
    tick();
    inst_cancel[2] = 1'b1;
    data_req[2]    = 1'b1;
    data_addr[2]   = 32'h1c000000;
    @(negedge clk);
    check("t4_cancel_inst_grant", inst_addr_ok[2], 0);
    check("t4_cancel_data_grant", data_addr_ok[2], 1);
    tick();
    inst_cancel[2] = 1'b0;
    inst_req[2]    = 1'b0;
    data_req[2]    = 1'b0;
    for (int c = 3; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("t4_no_inst_data_ok_c%0d", c), inst_data_ok[2], 0);
      tick();
    end
    @(negedge clk);
    check("t4_data_data_ok", data_data_ok[2], 1);
    check("t4_data_rdata", data_rdata[2], 32'h02800c0c);
    tick();

    // Reset mid-flight, LAT=2.
    inst_req[1]  = 1'b1;
    inst_addr[1] = 32'h1c000000;
    @(negedge clk);
    check("t5_addr_ok", inst_addr_ok[1], 1);
    tick();
    reset[1]      = 1'b1;
    inst_addr[1]  = 32'h4;
    data_req[1]   = 1'b1;
    data_we[1]    = 4'hf;
    data_addr[1]  = 32'h8;
    data_wdata[1] = 32'h12345678;
    @(negedge clk);
    check("t5_rst_inst_addr_ok", inst_addr_ok[1], 0);
    check("t5_rst_data_addr_ok", data_addr_ok[1], 0);
    check("t5_rst_inst_data_ok", inst_data_ok[1], 0);
    check("t5_rst_data_data_ok", data_data_ok[1], 0);
    check("t5_rst_sram_en", sram_en[1], 0);
    check("t5_rst_sram_we", sram_we[1], 0);
    check("t5_rst_sram_addr", sram_addr[1], 0);
    check("t5_rst_sram_wdata", sram_wdata[1], 0);
    check("t5_rst_inst_rdata", inst_rdata[1], 0);
    check("t5_rst_data_rdata", data_rdata[1], 0);
    tick();
    reset[1]    = 1'b0;
    inst_req[1] = 1'b0;
    data_req[1] = 1'b0;
    data_we[1]  = 4'h0;
    @(negedge clk);
    check("t5_post_inst_data_ok", inst_data_ok[1], 0);
    check("t5_post_data_data_ok", data_data_ok[1], 0);
    tick();

    // Starvation count is cleared by reset.
    inst_req[1] = 1'b1;
    data_req[1] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("t5_pre_data_grant_c%0d", c), data_addr_ok[1], 1);
      tick();
    end
    reset[1] = 1'b1;
    tick();
    reset[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("t5_post_inst_grant_c%0d", c), inst_addr_ok[1], (c == 3));
      check($sformatf("t5_post_data_grant_c%0d", c), data_addr_ok[1], (c != 3));
      tick();
    end
    inst_req[1] = 1'b0;
    data_req[1] = 1'b0;
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
